// File: rtl/alu_multiciclo_if.sv
// Request/response bundle between the pipeline control unit and the
// execution-stage ALU: operation launch plus the registered result handshake.
interface alu_multiciclo_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       aluChoice;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;
   logic             zero;

   modport master (
      output start, aluChoice, opA, opB,
      input  result, busy, done, zero
   );

   modport slave (
      input  start, aluChoice, opA, opB,
      output result, busy, done, zero
   );
endinterface

// File: rtl/alu_multiciclo.sv
// Execution-stage ALU: one-cycle integer ops plus iterative shift-add multiply
// and restoring divide (WIDTH+1 edges) behind a start/busy/done handshake.
module alu_multiciclo #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_multiciclo_if.slave aluBus
);
   localparam int              CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      negate = ~v + ONE;
   endfunction

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      magnitude = v[WIDTH-1] ? negate(v) : v;
   endfunction

   state_t             state_r;
   logic [CW-1:0]      cnt_r;
   logic [3:0]         opCode_r;
   logic               opIsDiv_r;
   logic               negRes_r;
   logic               signA_r;
   logic [WIDTH-1:0]   operand_r;
   logic [2*WIDTH-1:0] acc_r;

   logic [WIDTH-1:0]   quickResult_s;
   logic               quickOp_s;
   logic               minOverflow_s;
   logic               isDivOp_s;
   logic [CW-1:0]      shamt_s;
   logic [WIDTH:0]     mulSum_s;
   logic [WIDTH:0]     divShift_s;
   logic [WIDTH:0]     divDiff_s;
   logic [2*WIDTH-1:0] iterAcc_s;
   logic [2*WIDTH-1:0] product_s;
   logic [WIDTH-1:0]   fixResult_s;

   // Single-cycle results, including the division corners resolved at launch.
   always_comb begin
      quickResult_s = '0;
      quickOp_s     = 1'b1;
      shamt_s       = aluBus.opB[CW-1:0];
      minOverflow_s = (aluBus.opA == MIN_NEG) && (aluBus.opB == '1);
      isDivOp_s     = (aluBus.aluChoice == 4'd9) || (aluBus.aluChoice == 4'd10);
      case (aluBus.aluChoice)
         4'd0:  quickResult_s = aluBus.opA << shamt_s;
         4'd1:  quickResult_s = aluBus.opA >> shamt_s;
         4'd2:  quickResult_s = aluBus.opA + aluBus.opB;
         4'd3:  quickResult_s = aluBus.opA & aluBus.opB;
         4'd4:  quickResult_s = aluBus.opA | aluBus.opB;
         4'd5:  quickResult_s = aluBus.opA ^ aluBus.opB;
         4'd6:  quickResult_s = ($signed(aluBus.opA) < $signed(aluBus.opB)) ? ONE : '0;
         4'd7,
         4'd8:  quickOp_s = 1'b0;
         4'd9: begin
            if (aluBus.opB == '0) quickResult_s = '1;
            else if (minOverflow_s) quickResult_s = aluBus.opA;
            else quickOp_s = 1'b0;
         end
         4'd10: begin
            if (aluBus.opB == '0) quickResult_s = aluBus.opA;
            else if (minOverflow_s) quickResult_s = '0;
            else quickOp_s = 1'b0;
         end
         4'd11: quickResult_s = aluBus.opA - aluBus.opB;
         default: quickResult_s = '0;
      endcase
   end

   // One iteration step; acc holds {partial product} or {remainder, dividend/quotient}.
   always_comb begin
      mulSum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? operand_r : {WIDTH{1'b0}})};
      divShift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      divDiff_s  = divShift_s - {1'b0, operand_r};
      if (opIsDiv_r) begin
         if (!divDiff_s[WIDTH]) iterAcc_s = {divDiff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
         else iterAcc_s = {divShift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
         iterAcc_s = {mulSum_s, acc_r[WIDTH-1:1]};
      end
   end

   // Sign correction and result select at the end of the iterations.
   always_comb begin
      fixResult_s = '0;
      product_s   = negRes_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
      case (opCode_r)
         4'd7:    fixResult_s = product_s[WIDTH-1:0];
         4'd8:    fixResult_s = product_s[2*WIDTH-1:WIDTH];
         4'd9:    fixResult_s = negRes_r ? negate(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
         4'd10:   fixResult_s = signA_r ? negate(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
         default: fixResult_s = '0;
      endcase
   end

   // Control FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         opCode_r      <= 4'd0;
         opIsDiv_r     <= 1'b0;
         negRes_r      <= 1'b0;
         signA_r       <= 1'b0;
         operand_r     <= '0;
         acc_r         <= '0;
         aluBus.result <= '0;
         aluBus.busy   <= 1'b0;
         aluBus.done   <= 1'b0;
         aluBus.zero   <= 1'b1;
      end else begin
         aluBus.done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (aluBus.start && quickOp_s) begin
                  aluBus.result <= quickResult_s;
                  aluBus.zero   <= (quickResult_s == '0);
                  aluBus.done   <= 1'b1;
               end else if (aluBus.start) begin
                  state_r     <= ITER;
                  aluBus.busy <= 1'b1;
                  cnt_r       <= '0;
                  opCode_r    <= aluBus.aluChoice;
                  opIsDiv_r   <= isDivOp_s;
                  negRes_r    <= aluBus.opA[WIDTH-1] ^ aluBus.opB[WIDTH-1];
                  signA_r     <= aluBus.opA[WIDTH-1];
                  // Multiply walks opB's bits adding |opA|; divide shifts |opA| against |opB|.
                  operand_r   <= isDivOp_s ? magnitude(aluBus.opB) : magnitude(aluBus.opA);
                  acc_r       <= {{WIDTH{1'b0}},
                                  (isDivOp_s ? magnitude(aluBus.opA) : magnitude(aluBus.opB))};
               end else begin
                  state_r <= IDLE;
               end
            end
            ITER: begin
               acc_r <= iterAcc_s;
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_r == CNT_LAST) state_r <= FIX;
               else state_r <= ITER;
            end
            FIX: begin
               aluBus.result <= fixResult_s;
               aluBus.zero   <= (fixResult_s == '0);
               aluBus.done   <= 1'b1;
               aluBus.busy   <= 1'b0;
               state_r       <= IDLE;
            end
            default: begin
               state_r     <= IDLE;
               aluBus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: expected results queued at launch,
// compared when done pulses; latency and busy length checked per operation.
module tb_alu_multiciclo;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectorCount = 0;
   int   missCount = 0;
   int   doneCount = 0;
   int   pushCount = 0;
   logic [31:0] expQ[$];

   alu_multiciclo_if #(.WIDTH(32)) bus ();

   alu_multiciclo #(.WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .aluBus(bus)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectorCount++;
      if (got !== exp) begin
         missCount++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      case (op)
         4'd0:  refModel = a << b[4:0];
         4'd1:  refModel = a >> b[4:0];
         4'd2:  refModel = a + b;
         4'd3:  refModel = a & b;
         4'd4:  refModel = a | b;
         4'd5:  refModel = a ^ b;
         4'd6:  refModel = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd7:  refModel = p[31:0];
         4'd8:  refModel = p[63:32];
         4'd9:  refModel = (b == 32'd0) ? 32'hFFFF_FFFF :
                           ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'($signed(a) / $signed(b)));
         4'd10: refModel = (b == 32'd0) ? a :
                           ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'($signed(a) % $signed(b)));
         4'd11: refModel = a - b;
         default: refModel = 32'd0;
      endcase
   endfunction

   // Scoreboard: every done pops the oldest expected result.
   always @(negedge clk) begin
      if (bus.done) begin
         doneCount++;
         if (expQ.size() == 0) begin
            checkValue("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [31:0] e;
            e = expQ.pop_front();
            checkValue("result", bus.result, e);
            checkValue("zero", 32'(bus.zero), 32'(e == 32'd0));
         end
      end
   end

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int expLat, input int injectAt);
      int  lat;
      int  busyCnt;
      bit  seen;
      lat = -1; busyCnt = 0; seen = 1'b0;
      bus.start = 1'b1; bus.aluChoice = op; bus.opA = a; bus.opB = b;
      expQ.push_back(exp);
      pushCount++;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (i == 0) bus.start = 1'b0;
         if (injectAt != 0 && i == injectAt) begin
            bus.start = 1'b1; bus.aluChoice = 4'd2; bus.opA = 32'd1; bus.opB = 32'd2;
         end
         if (injectAt != 0 && i == injectAt + 1) bus.start = 1'b0;
         if (bus.busy) busyCnt++;
         if (bus.done) begin
            seen = 1'b1;
            lat = i;
         end
      end
      checkValue("latency", 32'(lat), 32'(expLat));
      checkValue("busy_cycles", 32'(busyCnt), 32'(expLat));
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [3:0]  opList [7];
      opList = '{4'd2, 4'd11, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10};
      bus.start = 1'b0; bus.aluChoice = 4'd0; bus.opA = 32'd0; bus.opB = 32'd0;
      repeat (2) @(negedge clk);
      checkValue("rst_result", bus.result, 32'd0);
      checkValue("rst_zero", 32'(bus.zero), 32'd1);
      checkValue("rst_busy", 32'(bus.busy), 32'd0);
      checkValue("rst_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkValue("idle_done", 32'(bus.done), 32'd0);

      runOp(4'd2,  32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 0, 0);
      runOp(4'd11, 32'd5,         32'd5,          32'd0,         0, 0);
      runOp(4'd0,  32'd1,         32'h23,         32'd8,         0, 0);
      runOp(4'd1,  32'h8000_0000, 32'd31,         32'd1,         0, 0);
      runOp(4'd6,  32'hFFFF_FFFF, 32'd1,          32'd1,         0, 0);
      runOp(4'd13, 32'h1234_5678, 32'h1111_1111,  32'd0,         0, 0);

      runOp(4'd7,  32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFEB, 33, 0);
      @(negedge clk);
      checkValue("done_once", 32'(bus.done), 32'd0);
      runOp(4'd8,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 33, 0);

      runOp(4'd9,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33, 0);
      runOp(4'd10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33, 0);
      runOp(4'd9,  32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 33, 0);
      runOp(4'd10, 32'd7,         32'hFFFF_FFFE,  32'd1,         33, 0);

      runOp(4'd9,  32'd9,         32'd0,          32'hFFFF_FFFF, 0, 0);
      runOp(4'd10, 32'd9,         32'd0,          32'd9,         0, 0);
      runOp(4'd9,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 0, 0);
      runOp(4'd10, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         0, 0);

      // Ignored mid-op start, then an add launched on a div's done cycle.
      runOp(4'd7,  32'd1000,      32'd12345,      32'd12345000,  33, 10);
      runOp(4'd9,  32'd100,       32'd7,          32'd14,        33, 0);
      runOp(4'd2,  32'd40,        32'd2,          32'd42,        0, 0);

      for (int i = 0; i < 8; i++) begin
         rop = opList[$urandom_range(0, 6)];
         ra  = $urandom;
         rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         runOp(rop, ra, rb, refModel(rop, ra, rb), (rop >= 4'd7 && rop <= 4'd10) ? 33 : 0, 0);
      end

      // Abort a divide mid-iteration with reset.
      bus.start = 1'b1; bus.aluChoice = 4'd9; bus.opA = 32'd100; bus.opB = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      checkValue("abort_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkValue("abort_busy", 32'(bus.busy), 32'd0);
      checkValue("abort_result", bus.result, 32'd0);
      checkValue("abort_zero", 32'(bus.zero), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkValue("abort_done", 32'(bus.done), 32'd0);
      end
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checkValue("abort_busy_after", 32'(bus.busy), 32'd0);

      checkValue("done_total", 32'(doneCount), 32'(pushCount));
      checkValue("queue_empty", 32'(expQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end
endmodule
